// File: rtl/lock_write_sequencer.sv
// rtl/lock_write_sequencer.sv - two-key lock sequencer in front of a lockable write register
// Accepts data writes until a KEY0/KEY1 pair locks the downstream register for good.
module lock_write_sequencer #(
   parameter int unsigned ARM_TIMEOUT = 16,
   parameter logic [7:0]  KEY0        = 8'hA5,
   parameter logic [7:0]  KEY1        = 8'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_lock,
   input  logic [7:0] req_data,
   output logic       resp_valid,
   output logic       resp_err,
   output logic       wr_en,
   output logic [7:0] data_in,
   output logic       lock_en,
   output logic       locked_o,
   output logic [3:0] wr_count
);

   localparam logic [7:0] TIMEOUT_C = 8'(ARM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_ARM,
      S_COMMIT,
      S_RESP,
      S_LOCKED
   } state_t;

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   logic       err_q, err_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] data_q, data_d;
   logic [3:0] cnt_q, cnt_d;
   logic       locked_q, locked_d;
   logic       accept;

   assign accept = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ret_q    <= S_IDLE;
         err_q    <= 1'b0;
         timer_q  <= 8'd0;
         data_q   <= 8'h00;
         cnt_q    <= 4'd0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         err_q    <= err_d;
         timer_q  <= timer_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   // Every request funnels through RESP; ret_q/err_q say where to go afterwards and what to report.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      err_d    = err_q;
      timer_d  = 8'd0;
      data_d   = data_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_lock) begin
                  state_d = S_RESP;
                  if (req_data == KEY0) begin
                     ret_d = S_ARM;
                     err_d = 1'b0;
                  end else begin
                     ret_d = S_IDLE;
                     err_d = 1'b1;
                  end
               end else begin
                  data_d  = req_data;
                  state_d = S_WR;
                  ret_d   = S_IDLE;
                  err_d   = 1'b0;
               end
            end
         end
         S_WR: begin
            state_d = S_RESP;
            if (cnt_q != 4'hF) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_ARM: begin
            // An accepted request takes precedence over a timeout landing in the same cycle.
            if (accept) begin
               if (req_lock && (req_data == KEY1)) begin
                  state_d = S_COMMIT;
                  ret_d   = S_LOCKED;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_RESP;
                  ret_d   = S_IDLE;
                  err_d   = 1'b1;
               end
            end else if ((timer_q + 8'd1) == TIMEOUT_C) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_COMMIT: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = ret_q;
            if (ret_q == S_LOCKED) begin
               locked_d = 1'b1;
            end
         end
         S_LOCKED: begin
            if (accept) begin
               state_d = S_RESP;
               ret_d   = S_LOCKED;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready  = !rst && ((state_q == S_IDLE) || (state_q == S_ARM) || (state_q == S_LOCKED));
      resp_valid = (state_q == S_RESP);
      resp_err   = (state_q == S_RESP) && err_q;
      wr_en      = (state_q == S_WR);
      lock_en    = (state_q == S_COMMIT);
      locked_o   = locked_q;
      data_in    = data_q;
      wr_count   = cnt_q;
   end

endmodule

// File: tb/tb_lock_write_sequencer.sv
// tb/tb_lock_write_sequencer.sv - directed self-checking bench for lock_write_sequencer
module tb_lock_write_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_lock;
    logic [7:0] req_data;
    logic       resp_valid;
    logic       resp_err;
    logic       wr_en;
    logic [7:0] data_in;
    logic       lock_en;
    logic       locked_o;
    logic [3:0] wr_count;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cnt;

    lock_write_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_lock   (req_lock),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .lock_en    (lock_en),
        .locked_o   (locked_o),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] d);
        req_valid = v;
        req_lock  = l;
        req_data  = d;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick;
        tick;
        check("rst_ready", req_ready, 1'b0);
        check("rst_data_in", data_in, 8'h00);
        check("rst_wr_count", wr_count, 4'h0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_locked", locked_o, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_lock_en", lock_en, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1'b1);

        drive(1'b1, 1'b0, 8'h3C);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("w1_wr_en", wr_en, 1'b1);
        check("w1_data_in", data_in, 8'h3C);
        check("w1_no_resp_yet", resp_valid, 1'b0);
        check("w1_ready_low", req_ready, 1'b0);
        tick;
        check("w1_resp_valid", resp_valid, 1'b1);
        check("w1_resp_err", resp_err, 1'b0);
        check("w1_wr_en_pulse", wr_en, 1'b0);
        check("w1_wr_count", wr_count, 4'h1);
        tick;
        check("w1_back_idle", req_ready, 1'b1);
        check("w1_resp_pulse", resp_valid, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'h10 + i[7:0]);
            tick;
            drive(1'b0, 1'b0, 8'h00);
            tick;
            tick;
            exp_cnt = (i + 2 > 15) ? 4'hF : 4'(i + 2);
            check("sat_wr_count", wr_count, exp_cnt);
        end
        check("sat_data_in", data_in, 8'h1F);

        drive(1'b1, 1'b1, 8'hA5);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("arm_w_key0_valid", resp_valid, 1'b1);
        check("arm_w_key0_err", resp_err, 1'b0);
        tick;
        check("arm_w_ready", req_ready, 1'b1);
        drive(1'b1, 1'b0, 8'h11);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("arm_w_resp_valid", resp_valid, 1'b1);
        check("arm_w_resp_err", resp_err, 1'b1);
        check("arm_w_no_wr_en", wr_en, 1'b0);
        check("arm_w_data_hold", data_in, 8'h1F);
        tick;
        check("arm_w_idle_ready", req_ready, 1'b1);
        check("arm_w_count_hold", wr_count, 4'hF);

        drive(1'b1, 1'b1, 8'hA5);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("to_key0_err", resp_err, 1'b0);
        tick;
        for (int i = 0; i < 16; i++) begin
            check("to_arm_quiet", resp_valid, 1'b0);
            tick;
        end
        drive(1'b1, 1'b1, 8'h5A);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("to_key1_valid", resp_valid, 1'b1);
        check("to_key1_err", resp_err, 1'b1);
        check("to_no_lock_en", lock_en, 1'b0);
        tick;

        drive(1'b1, 1'b1, 8'hA5);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        tick;
        for (int i = 0; i < 15; i++) begin
            tick;
        end
        drive(1'b1, 1'b0, 8'h77);
        check("edge_ready", req_ready, 1'b1);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("edge_resp_valid", resp_valid, 1'b1);
        check("edge_resp_err", resp_err, 1'b1);
        check("edge_no_wr_en", wr_en, 1'b0);
        check("edge_data_hold", data_in, 8'h1F);
        tick;

        drive(1'b1, 1'b1, 8'hA5);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("lk_key0_valid", resp_valid, 1'b1);
        check("lk_key0_err", resp_err, 1'b0);
        tick;
        tick;
        drive(1'b1, 1'b1, 8'h5A);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("lk_lock_en", lock_en, 1'b1);
        check("lk_commit_no_wr", wr_en, 1'b0);
        check("lk_commit_no_resp", resp_valid, 1'b0);
        tick;
        check("lk_key1_valid", resp_valid, 1'b1);
        check("lk_key1_err", resp_err, 1'b0);
        check("lk_lock_en_pulse", lock_en, 1'b0);
        check("lk_not_yet_locked", locked_o, 1'b0);
        tick;
        check("lk_locked", locked_o, 1'b1);
        check("lk_ready", req_ready, 1'b1);
        drive(1'b1, 1'b0, 8'hFF);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("lk_w_valid", resp_valid, 1'b1);
        check("lk_w_err", resp_err, 1'b1);
        check("lk_w_no_wr_en", wr_en, 1'b0);
        check("lk_w_no_lock_en", lock_en, 1'b0);
        check("lk_w_data_hold", data_in, 8'h1F);
        check("lk_w_still_locked", locked_o, 1'b1);
        tick;
        check("lk_back_ready", req_ready, 1'b1);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("r2_wr_count", wr_count, 4'h0);
        check("r2_data_in", data_in, 8'h00);
        check("r2_unlocked", locked_o, 1'b0);
        drive(1'b1, 1'b1, 8'hA5);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        tick;
        drive(1'b1, 1'b1, 8'h5A);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("rc_commit", lock_en, 1'b1);
        rst = 1'b1;
        tick;
        check("rc_no_resp", resp_valid, 1'b0);
        check("rc_not_locked", locked_o, 1'b0);
        check("rc_no_lock_en", lock_en, 1'b0);
        check("rc_ready_in_rst", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rc_ready_after", req_ready, 1'b1);
        drive(1'b1, 1'b0, 8'h3C);
        tick;
        drive(1'b0, 1'b0, 8'h00);
        check("rc_w_wr_en", wr_en, 1'b1);
        check("rc_w_data_in", data_in, 8'h3C);
        tick;
        check("rc_w_resp_valid", resp_valid, 1'b1);
        check("rc_w_resp_err", resp_err, 1'b0);
        check("rc_w_count", wr_count, 4'h1);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_write_sequencer.md
LOCK_WRITE_SEQUENCER -- requirements
Module: lock_write_sequencer

Interface
REQ-001 Parameter: ARM_TIMEOUT, default 16, max ARM-state cycles awaiting the second key before abort (legal 2..255).
REQ-002 Parameter: KEY0, default 8'hA5, first lock key.
REQ-003 Parameter: KEY1, default 8'h5A, second lock key.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  host request valid.
REQ-007 req_ready  output  1  block can accept a request; transfer when req_valid && req_ready.
REQ-008 req_lock  input  1  1 = lock-key request, 0 = data write request.
REQ-009 req_data  input  8  write data, or key byte when req_lock=1.
REQ-010 resp_valid  output  1  one-cycle response pulse, exactly one per accepted request; no backpressure.
REQ-011 resp_err  output  1  qualifies resp_valid: 1 = rejected, 0 = success.
REQ-012 wr_en  output  1  write strobe to the downstream lockable register.
REQ-013 data_in  output  8  write data to the downstream register, registered.
REQ-014 lock_en  output  1  one-cycle lock pulse to the downstream register.
REQ-015 locked_o  output  1  high while in LOCKED.
REQ-016 wr_count  output  4  successful writes since reset, saturating.

Function
REQ-017 States SHALL be IDLE, WR, ARM, COMMIT, RESP, LOCKED; req_ready=1 only in IDLE, ARM and LOCKED.
REQ-018 IDLE, write accepted (req_lock=0) at cycle N: data_in<=req_data, WR at N+1 with wr_en=1, RESP at N+2 with resp_valid=1, resp_err=0, then IDLE.
REQ-019 IDLE, lock accepted with req_data==KEY0: RESP next cycle, resp_err=0, then ARM with the arm timer cleared.
REQ-020 IDLE, lock accepted with req_data!=KEY0: RESP, resp_err=1, then IDLE; no lock_en.
REQ-021 ARM: timer increments each cycle with no accepted request; when it reaches ARM_TIMEOUT the FSM SHALL return to IDLE with no response.
REQ-022 ARM, lock accepted with req_data==KEY1: COMMIT next cycle with lock_en=1, then RESP with resp_err=0, then LOCKED.
REQ-023 ARM, write request or lock with wrong key accepted: RESP, resp_err=1, then IDLE; no wr_en and data_in unchanged.
REQ-024 ARM, accept in the same cycle the timer would expire: accept wins.
REQ-025 LOCKED: every accepted request gets RESP with resp_err=1, returning to LOCKED; wr_en, lock_en never asserted; exit only via rst.
REQ-026 wr_en and lock_en SHALL be single-cycle pulses, never high in the same cycle.
REQ-027 data_in SHALL change only on an accepted IDLE write and hold otherwise.
REQ-028 wr_count increments in the WR cycle and saturates at 4'hF.
REQ-029 locked_o goes high the cycle LOCKED is entered, one cycle after resp_valid for the KEY1 request.
REQ-030 resp_valid SHALL be high only in RESP; resp_err is 0 whenever resp_valid=0.

Reset
REQ-031 rst=1 at a rising edge forces state IDLE, arm timer 0, data_in=8'h00, wr_count=0, wr_en=0, lock_en=0, resp_valid=0, resp_err=0, locked_o=0, taking priority over every transition.
REQ-032 Reset mid-operation (WR, COMMIT, RESP) discards the in-flight request: no strobe and no response after the reset edge.
REQ-033 req_ready is 0 during the reset cycle and 1 in the first cycle after rst deasserts.

Verification
REQ-034 Write 8'h3C in IDLE -> wr_en=1 with data_in=8'h3C at N+1, resp_valid=1 with resp_err=0 at N+2, wr_count=1.
REQ-035 Lock A5, then lock 5A 3 cycles later -> lock_en pulse once, resp ok for both, locked_o=1; then write 8'hFF -> resp_err=1, no wr_en, data_in unchanged.
REQ-036 Lock A5, then idle 16 cycles -> return to IDLE with no response; a following lock 5A -> resp_err=1, no lock_en.
REQ-037 Lock A5, then write 8'h11 -> resp_err=1, no wr_en, state IDLE, data_in unchanged.
REQ-038 17 writes -> wr_count saturates at 4'hF.
REQ-039 Assert rst in the COMMIT cycle -> no resp_valid and locked_o=0; the next write succeeds.
